truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of DUT inputs driven, legal range 1..8.
REQ-002 SHALL have parameter HOLD, default 10: clock cycles each input vector is held, legal range 1..255.
REQ-003 SHALL have parameter EXPECT, width 2**N_IN, default 8'b0000_0000: golden truth table; bit i is the expected DUT output for input vector i.
REQ-004 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  begin a sweep; sampled on rising edge.
REQ-007 SHALL have port: dut_in  output  N_IN  current stimulus vector to the circuit under test.
REQ-008 SHALL have port: dut_out  input  1  response of the circuit under test.
REQ-009 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port: sample  output  1  high during the cycle in which dut_out is compared.
REQ-011 SHALL have port: done  output  1  high after a sweep completes, until the next start or reset.
REQ-012 SHALL have port: mismatch_count  output  N_IN+1  number of failing vectors in the current or last sweep.
REQ-013 SHALL have port: fail_seen  output  1  high once any mismatch has been recorded.
REQ-014 SHALL have port: first_fail  output  N_IN  lowest-index failing vector; valid only while fail_seen=1.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, DONE; all outputs registered except sample.
REQ-016 SHALL, in IDLE or DONE with start=1, enter DRIVE next edge: dut_in=0, hold counter=0, mismatch_count=0, fail_seen=0, first_fail=0, done=0, busy=1.
REQ-017 SHALL ignore start while in DRIVE; the sweep in progress is unaffected.
REQ-018 SHALL hold each vector exactly HOLD cycles; sample=1 (combinational) when state=DRIVE and hold counter=HOLD-1, else 0.
REQ-019 SHALL, on the edge ending a sample cycle, compare dut_out to EXPECT[dut_in]; on inequality increment mismatch_count and, if fail_seen=0, load first_fail=dut_in and set fail_seen=1.
REQ-020 SHALL, on that same edge, set hold counter=0 and dut_in=dut_in+1 if dut_in<2**N_IN-1.
REQ-021 SHALL, if dut_in=2**N_IN-1 on that edge, enter DONE: busy=0, done=1, dut_in holds last vector; final compare still recorded.
REQ-022 SHALL keep busy high for exactly HOLD*2**N_IN cycles per sweep; done rises on the edge busy falls.
REQ-023 SHALL never wrap or saturate mismatch_count; width N_IN+1 covers the maximum 2**N_IN.
REQ-024 SHALL, with HOLD=1, assert sample every DRIVE cycle and advance dut_in every cycle.
REQ-025 SHALL retain mismatch_count, fail_seen, first_fail in DONE until start or reset.

Reset
REQ-026 SHALL, on any edge with reset=1, regardless of state or start, go to IDLE: dut_in=0, busy=0, done=0, mismatch_count=0, fail_seen=0, first_fail=0, hold counter=0.
REQ-027 SHALL give reset priority over start and over an in-progress compare in the same cycle; a mid-sweep reset discards the partial sweep.

Verification
REQ-028 SHALL cover: N_IN=3, HOLD=10, EXPECT=8'b1001_0110, DUT = XOR of inputs, start pulse -> dut_in steps 0..7 every 10 cycles, busy 80 cycles, done=1, mismatch_count=0, fail_seen=0.
REQ-029 SHALL cover: same, DUT output forced wrong only for vector 5 -> mismatch_count=1, fail_seen=1, first_fail=5.
REQ-030 SHALL cover: same, DUT = XNOR -> mismatch_count=8 (no wrap), first_fail=0.
REQ-031 SHALL cover: reset asserted at cycle 35 of a sweep -> next edge IDLE, all outputs 0; new start then gives full clean 80-cycle sweep.
REQ-032 SHALL cover: start re-pulsed at cycle 20 of a sweep -> ignored, done at cycle 80; start in DONE -> counters cleared, new sweep.
REQ-033 SHALL cover: N_IN=1, HOLD=1, EXPECT=2'b10, DUT = buffer -> sample high 2 consecutive cycles, busy 2 cycles, mismatch_count=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to an external circuit,
// holds each one for HOLD cycles and compares the response against a golden table.
module truth_table_sweeper #(
  parameter int unsigned                N_IN   = 3,
  parameter int unsigned                HOLD   = 10,
  parameter logic [(1 << N_IN)-1:0]     EXPECT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            sample,
  output logic            done,
  output logic [N_IN:0]   mismatch_count,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] LAST_VEC  = '1;
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            fail_q, fail_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            sample_s;
  logic            vec_fail_s;

  // Compare strobe is the last cycle a vector is held; it is the only unregistered output.
  assign sample_s   = (state_q == DRIVE) && (hold_q == HOLD_LAST);
  assign vec_fail_s = (dut_out != EXPECT[vec_q]);

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    first_d = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          hold_d  = 8'd0;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          fail_d  = 1'b0;
          first_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      DRIVE: begin
        if (sample_s) begin
          // Only the first failure latches its index, so the lowest failing vector is kept.
          if (vec_fail_s) begin
            cnt_d = cnt_q + CNT_ONE;
            if (!fail_q) begin
              fail_d  = 1'b1;
              first_d = vec_q;
            end else begin
              first_d = first_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          hold_d = 8'd0;
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
        vec_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
        fail_d  = 1'b0;
        first_d = '0;
      end
    endcase
  end

  // State and output registers; reset wins over start and over a pending compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  assign dut_in         = vec_q;
  assign busy           = busy_q;
  assign sample         = sample_s;
  assign done           = done_q;
  assign mismatch_count = cnt_q;
  assign fail_seen      = fail_q;
  assign first_fail     = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 3-input XOR sweep with injectable per-vector faults,
// plus a 1-input, HOLD=1 instance exercising the minimum configuration.
module tb_truth_table_sweeper;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, sample, done, fail_seen;
  logic [3:0] mismatch_count;
  logic [2:0] first_fail;
  logic [7:0] fault_mask;

  logic       start_s;
  logic [0:0] dut_in_s;
  logic       dut_out_s;
  logic       busy_s, sample_s, done_s, fail_seen_s;
  logic [1:0] mismatch_count_s;
  logic [0:0] first_fail_s;
  logic       small_flip;

  int checks = 0;
  int errors = 0;

  truth_table_sweeper #(.N_IN(3), .HOLD(10), .EXPECT(8'b1001_0110)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .sample(sample), .done(done), .mismatch_count(mismatch_count),
    .fail_seen(fail_seen), .first_fail(first_fail)
  );

  truth_table_sweeper #(.N_IN(1), .HOLD(1), .EXPECT(2'b10)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .dut_in(dut_in_s), .dut_out(dut_out_s),
    .busy(busy_s), .sample(sample_s), .done(done_s), .mismatch_count(mismatch_count_s),
    .fail_seen(fail_seen_s), .first_fail(first_fail_s)
  );

  // Circuit under test: 3-input XOR with selectable wrong answers; 1-bit buffer.
  assign dut_out   = (^dut_in) ^ fault_mask[dut_in];
  assign dut_out_s = dut_in_s[0] ^ small_flip;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int popcount8(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int lowest8(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b done=%0b sample=%0b expected 0 0 0", busy, done, sample); end
    checks++; if (dut_in !== 3'd0 || mismatch_count !== 4'd0) begin errors++; $display("FAIL reset_vec_cnt got dut_in=%0d cnt=%0d expected 0 0", dut_in, mismatch_count); end
    checks++; if (fail_seen !== 1'b0 || first_fail !== 3'd0) begin errors++; $display("FAIL reset_fail got fail_seen=%0b first=%0d expected 0 0", fail_seen, first_fail); end
    checks++; if (busy_s !== 1'b0 || done_s !== 1'b0 || mismatch_count_s !== 2'd0) begin errors++; $display("FAIL reset_small got busy=%0b done=%0b cnt=%0d expected 0 0 0", busy_s, done_s, mismatch_count_s); end
    reset = 1'b0;
  endtask

  task automatic test_sweep_pass();
    int bad_vec = 0, bad_smp = 0, bad_busy = 0;
    fault_mask = 8'h00;
    pulse_start();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (dut_in !== 3'(k / 10)) bad_vec++;
      if (sample !== ((k % 10) == 9)) bad_smp++;
      if (busy !== 1'b1) bad_busy++;
    end
    checks++; if (bad_vec != 0) begin errors++; $display("FAIL pass_vector_steps got %0d bad cycles expected 0", bad_vec); end
    checks++; if (bad_smp != 0) begin errors++; $display("FAIL pass_sample_timing got %0d bad cycles expected 0", bad_smp); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL pass_busy_high got %0d bad cycles expected 0", bad_busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL pass_end_flags got busy=%0b done=%0b expected 0 1", busy, done); end
    checks++; if (mismatch_count !== 4'd0 || fail_seen !== 1'b0) begin errors++; $display("FAIL pass_result got cnt=%0d fail_seen=%0b expected 0 0", mismatch_count, fail_seen); end
    checks++; if (dut_in !== 3'd7 || sample !== 1'b0) begin errors++; $display("FAIL pass_hold_last got dut_in=%0d sample=%0b expected 7 0", dut_in, sample); end
  endtask

  task automatic test_single_fault();
    int cyc;
    fault_mask = 8'b0010_0000;
    pulse_start();
    wait_done(cyc);
    checks++; if (cyc != 80) begin errors++; $display("FAIL fault5_busy_len got %0d expected 80", cyc); end
    checks++; if (mismatch_count !== 4'd1 || fail_seen !== 1'b1 || first_fail !== 3'd5) begin errors++; $display("FAIL fault5_result got cnt=%0d fail_seen=%0b first=%0d expected 1 1 5", mismatch_count, fail_seen, first_fail); end
  endtask

  task automatic test_xnor();
    int cyc;
    fault_mask = 8'hFF;
    pulse_start();
    wait_done(cyc);
    checks++; if (mismatch_count !== 4'd8) begin errors++; $display("FAIL xnor_count got %0d expected 8", mismatch_count); end
    checks++; if (fail_seen !== 1'b1 || first_fail !== 3'd0 || done !== 1'b1) begin errors++; $display("FAIL xnor_flags got fail_seen=%0b first=%0d done=%0b expected 1 0 1", fail_seen, first_fail, done); end
  endtask

  task automatic test_random_faults();
    int cyc;
    for (int it = 0; it < 8; it++) begin
      fault_mask = 8'($urandom);
      pulse_start();
      wait_done(cyc);
      checks++; if (cyc != 80) begin errors++; $display("FAIL rand_busy_len mask=%h got %0d expected 80", fault_mask, cyc); end
      checks++; if (int'(mismatch_count) != popcount8(fault_mask)) begin errors++; $display("FAIL rand_count mask=%h got %0d expected %0d", fault_mask, mismatch_count, popcount8(fault_mask)); end
      checks++; if (fail_seen !== (fault_mask != 8'h00)) begin errors++; $display("FAIL rand_fail_seen mask=%h got %0b expected %0b", fault_mask, fail_seen, fault_mask != 8'h00); end
      if (fault_mask != 8'h00) begin
        checks++; if (int'(first_fail) != lowest8(fault_mask)) begin errors++; $display("FAIL rand_first mask=%h got %0d expected %0d", fault_mask, first_fail, lowest8(fault_mask)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    fault_mask = 8'b0000_0001;
    pulse_start();
    repeat (35) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0 || dut_in !== 3'd0) begin errors++; $display("FAIL midreset_flags got busy=%0b done=%0b sample=%0b dut_in=%0d expected 0 0 0 0", busy, done, sample, dut_in); end
    checks++; if (mismatch_count !== 4'd0 || fail_seen !== 1'b0 || first_fail !== 3'd0) begin errors++; $display("FAIL midreset_clear got cnt=%0d fail_seen=%0b first=%0d expected 0 0 0", mismatch_count, fail_seen, first_fail); end
    fault_mask = 8'h00;
    pulse_start();
    wait_done(cyc);
    checks++; if (cyc != 80 || mismatch_count !== 4'd0 || done !== 1'b1) begin errors++; $display("FAIL midreset_resweep got len=%0d cnt=%0d done=%0b expected 80 0 1", cyc, mismatch_count, done); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, rem;
    fault_mask = 8'b0000_0100;
    pulse_start();
    repeat (20) begin @(posedge clk); #1; cyc++; end
    start = 1'b1;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    wait_done(rem);
    checks++; if (cyc + rem != 80) begin errors++; $display("FAIL restart_ignored_len got %0d expected 80", cyc + rem); end
    checks++; if (mismatch_count !== 4'd1 || first_fail !== 3'd2 || done !== 1'b1) begin errors++; $display("FAIL restart_ignored_result got cnt=%0d first=%0d done=%0b expected 1 2 1", mismatch_count, first_fail, done); end
    fault_mask = 8'h00;
    pulse_start();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || dut_in !== 3'd0) begin errors++; $display("FAIL done_restart_flags got busy=%0b done=%0b dut_in=%0d expected 1 0 0", busy, done, dut_in); end
    checks++; if (mismatch_count !== 4'd0 || fail_seen !== 1'b0 || first_fail !== 3'd0) begin errors++; $display("FAIL done_restart_clear got cnt=%0d fail_seen=%0b first=%0d expected 0 0 0", mismatch_count, fail_seen, first_fail); end
    wait_done(rem);
    checks++; if (rem != 80 || mismatch_count !== 4'd0) begin errors++; $display("FAIL done_restart_sweep got len=%0d cnt=%0d expected 80 0", rem, mismatch_count); end
  endtask

  task automatic test_small();
    for (int f = 0; f < 2; f++) begin
      small_flip = f[0];
      @(posedge clk); #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0;
      @(negedge clk);
      checks++; if (sample_s !== 1'b1 || dut_in_s !== 1'b0 || busy_s !== 1'b1) begin errors++; $display("FAIL small_cycle0 flip=%0d got sample=%0b dut_in=%0d busy=%0b expected 1 0 1", f, sample_s, dut_in_s, busy_s); end
      @(negedge clk);
      checks++; if (sample_s !== 1'b1 || dut_in_s !== 1'b1 || busy_s !== 1'b1) begin errors++; $display("FAIL small_cycle1 flip=%0d got sample=%0b dut_in=%0d busy=%0b expected 1 1 1", f, sample_s, dut_in_s, busy_s); end
      @(posedge clk); #1;
      checks++; if (busy_s !== 1'b0 || done_s !== 1'b1 || sample_s !== 1'b0) begin errors++; $display("FAIL small_end flip=%0d got busy=%0b done=%0b sample=%0b expected 0 1 0", f, busy_s, done_s, sample_s); end
      checks++; if (int'(mismatch_count_s) != 2 * f || fail_seen_s !== f[0] || first_fail_s !== 1'b0) begin errors++; $display("FAIL small_result flip=%0d got cnt=%0d fail_seen=%0b first=%0d expected %0d %0d 0", f, mismatch_count_s, fail_seen_s, first_fail_s, 2 * f, f); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    fault_mask = 8'h00; small_flip = 1'b0;
    test_reset();
    test_sweep_pass();
    test_single_fault();
    test_xnor();
    test_random_faults();
    test_mid_reset();
    test_back_to_back();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
